mem_display_sequencer: RTL and testbench
========================================

Name: mem_display_sequencer

Overview:
Sequences memory reads for the 4-digit LED display. Walks an 8-bit address range, issues read requests to the memory controller over a req/ack handshake, and latches each address/data pair into the four display nibbles (ad_high, ad_low, d_high, d_low). Feeds display_controller directly. Supports an auto mode (timed hold) and a manual mode (step per button press).

Parameters:
HOLD_CYCLES, 50000000, clk cycles each address/data pair is held in auto mode (>=1)
ACK_TIMEOUT, 255, cycles to wait for rd_ack before abort; used only with MEMSEQ_ACK_TIMEOUT_EN

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  begin scan; sampled only in IDLE
stop  in  1  abort scan, return to IDLE
step  in  1  manual advance; rising edge detected internally
auto_mode  in  1  1 = timed advance, 0 = step advance
start_addr  in  8  first address
end_addr  in  8  last address (inclusive)
rd_req  out  1  read request to memory controller
rd_addr  out  8  read address
rd_ack  in  1  1-cycle read acknowledge; rd_data valid same cycle
rd_data  in  8  read data
ad_high, ad_low  out  4 each  displayed address nibbles
d_high, d_low  out  4 each  displayed data nibbles
busy  out  1  high when not IDLE
done  out  1  1-cycle pulse when the final address completes
err  out  1  sticky ack-timeout flag

Behaviour:
- One clock, synchronous active-high reset. All outputs are registered.
- Reset: state=IDLE; addr_q=0; rd_req=0; rd_addr=0; all display nibbles=0; busy=0; done=0; err=0; step edge register=0.
- States: IDLE, REQ, HOLD.
- IDLE:
  - start=1: addr_q<=start_addr, err<=0, go REQ.
  - rd_req rises the cycle after start is sampled (latency 1).
  - Display retains its last values.
- REQ:
  - rd_req=1, rd_addr=addr_q.
  - On rd_ack=1, at the same edge: {ad_high,ad_low}<=addr_q, {d_high,d_low}<=rd_data, rd_req<=0, hold_cnt<=0, go HOLD.
  - Display updates 1 cycle after ack.
- HOLD:
  - rd_req=0.
  - auto_mode=1: advance when hold_cnt==HOLD_CYCLES-1.
  - auto_mode=0: advance on a 0->1 transition of step. A held step level advances once only.
  - auto_mode may change mid-HOLD; hold_cnt keeps counting regardless of mode.
- Advance:
  - If addr_q==end_addr: done<=1 for 1 cycle, go IDLE.
  - Otherwise: addr_q<=addr_q+1 (mod 256, 0xFF->0x00), go REQ.
- Range rules:
  - end_addr<start_addr: scan wraps through 0xFF->0x00 to end_addr.
  - start_addr==end_addr: single read, then done.
- stop=1 in REQ or HOLD:
  - Go IDLE next cycle; rd_req<=0; display frozen; no done pulse.
  - stop with rd_ack in the same cycle: stop wins, rd_data discarded.
- Ignored inputs: start while busy; rd_ack outside REQ; step in IDLE/REQ (the edge register still tracks step).
- Priority: reset > stop > rd_ack/advance > start.
- busy = (state!=IDLE), registered alongside state.

Optional Feature:
MEMSEQ_ACK_TIMEOUT_EN
- Defined: a timeout counter runs in REQ. After ACK_TIMEOUT cycles with no ack: rd_req<=0, d_high/d_low<=4'hE/4'hE, address shown normally, err<=1 (sticky until next accepted start or reset), go HOLD and continue the scan.
- Undefined: REQ waits indefinitely; err tied to 0; no counter logic.

Decomposition:
- Shared package (mem_disp_pkg): state encoding constants ST_IDLE=2'd0, ST_REQ=2'd1, ST_HOLD=2'd2; ERR_NIBBLE=4'hE; ADDR_W=8, DATA_W=8.
- Sub-module seq_hold_timer: clear/enable counter with terminal-count output, parameterised by HOLD_CYCLES. Reused for the ack timeout when the feature is enabled.

Test Plan (HOLD_CYCLES=4, ACK_TIMEOUT=8):
- Reset, then idle 10 cycles -> all nibbles 0, rd_req=0, busy=0, done=0.
- auto_mode=1, start_addr=0x10, end_addr=0x12, memory acks after 2 cycles with data=addr^0xA5 -> rd_addr 0x10, 0x11, 0x12 in order; display shows 1,0,B,5 then 1,1,B,4 then 1,2,B,7; each pair held 4 cycles; one done pulse; busy falls with done.
- auto_mode=0, start_addr=end_addr=0x3C, step held high 20 cycles after first display -> exactly one read; done after first step edge; no second read.
- start_addr=0xFE, end_addr=0x01, auto -> reads 0xFE, 0xFF, 0x00, 0x01; done after 0x01.
- stop asserted in the same cycle as rd_ack during address 0x21 -> display keeps the previous pair (0x20 data); IDLE next cycle; rd_req=0; no done; a start 3 cycles later restarts from start_addr.
- MEMSEQ_ACK_TIMEOUT_EN defined, memory never acks at 0x05 -> rd_req drops after 8 cycles; display shows 0,5,E,E; err=1; scan continues; err cleared on next start.

Source files
------------

// File: rtl/mem_disp_pkg.sv
// Shared types and constants for the memory display sequencer.
package mem_disp_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  localparam logic [3:0] ERR_NIBBLE = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mem_display_sequencer_seq_hold_timer.sv
// Clear/enable up-counter with terminal-count flag; saturates at CYCLES-1.
module seq_hold_timer #(
  parameter int unsigned CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Saturating so that a mode switch after the hold has elapsed advances at once.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/mem_display_sequencer.sv
// Walks an address range, reads memory over req/ack and latches addr/data into display nibbles.
// Optional ack timeout enabled by defining MEMSEQ_ACK_TIMEOUT_EN.
module mem_display_sequencer
  import mem_disp_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              step,
  input  logic              auto_mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic [3:0]        ad_high,
  output logic [3:0]        ad_low,
  output logic [3:0]        d_high,
  output logic [3:0]        d_low,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic [DATA_W-1:0] disp_data_q, disp_data_d;
  logic              rd_req_d, busy_d, done_d;
  logic              step_q, step_rise, hold_tc, ack_tmo, advance, last_addr;

  assign step_rise = step & ~step_q;
  assign advance   = auto_mode ? hold_tc : step_rise;
  assign last_addr = (addr_q == end_addr);

  seq_hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != ST_HOLD),
    .enable (1'b1),
    .tc     (hold_tc)
  );

`ifdef MEMSEQ_ACK_TIMEOUT_EN
  logic err_q;

  seq_hold_timer #(.CYCLES(ACK_TIMEOUT)) u_ack_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != ST_REQ),
    .enable (1'b1),
    .tc     (ack_tmo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == ST_IDLE && start && !stop) begin
      err_q <= 1'b0;
    end else if (state_q == ST_REQ && !stop && !rd_ack && ack_tmo) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_ack_timeout;

  assign ack_tmo            = 1'b0;
  assign err                = 1'b0;
  assign unused_ack_timeout = (ACK_TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      disp_addr_q <= '0;
      disp_data_q <= '0;
      rd_req      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      disp_addr_q <= disp_addr_d;
      disp_data_q <= disp_data_d;
      rd_req      <= rd_req_d;
      busy        <= busy_d;
      done        <= done_d;
      step_q      <= step;
    end
  end

  // stop outranks ack/advance, which outrank start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_REQ;
      ST_REQ: begin
        if (stop)                   state_d = ST_IDLE;
        else if (rd_ack || ack_tmo) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (stop)         state_d = ST_IDLE;
        else if (advance) state_d = last_addr ? ST_IDLE : ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    disp_addr_d = disp_addr_q;
    disp_data_d = disp_data_q;
    done_d      = 1'b0;
    rd_req_d    = (state_d == ST_REQ);
    busy_d      = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: if (start && !stop) addr_d = start_addr;
      ST_REQ: begin
        if (!stop && (rd_ack || ack_tmo)) begin
          disp_addr_d = addr_q;
          disp_data_d = rd_ack ? rd_data : {ERR_NIBBLE, ERR_NIBBLE};
        end
      end
      ST_HOLD: begin
        if (!stop && advance) begin
          if (last_addr) done_d = 1'b1;
          else           addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign rd_addr = addr_q;
  assign ad_high = disp_addr_q[7:4];
  assign ad_low  = disp_addr_q[3:0];
  assign d_high  = disp_data_q[7:4];
  assign d_low   = disp_data_q[3:0];

endmodule

// File: tb/tb_mem_display_sequencer.sv
// Directed bench for mem_display_sequencer with HOLD_CYCLES=4, ACK_TIMEOUT=8.
module tb_mem_display_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, stop, step, auto_mode;
  logic [7:0] start_addr, end_addr, rd_addr, rd_data;
  logic       rd_req, rd_ack;
  logic [3:0] ad_high, ad_low, d_high, d_low;
  logic       busy, done, err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned req_age  = 0;
  logic        nack_en  = 1'b0;
  logic [7:0]  nack_addr = 8'h00;

  typedef struct {
    logic [7:0]  s;
    logic [7:0]  e;
    int unsigned n;
  } scan_vec_t;

  scan_vec_t vecs[4];

  mem_display_sequencer #(.HOLD_CYCLES(4), .ACK_TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .auto_mode  (auto_mode),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .ad_high    (ad_high),
    .ad_low     (ad_low),
    .d_high     (d_high),
    .d_low      (d_low),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance one clock, sample #1 after the edge, then drive the memory model's ack for the next edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rd_req) begin
      req_age++;
      rd_ack = (req_age == 2) && !(nack_en && rd_addr == nack_addr);
    end else begin
      req_age = 0;
      rd_ack  = 1'b0;
    end
    rd_data = rd_addr ^ 8'hA5;
  endtask

  task automatic run_scan(input logic [7:0] s, input logic [7:0] e, input int unsigned n_exp);
    logic [7:0]  exp_a, cur_a;
    int unsigned reads, gap;
    logic        prev_req, in_hold, acked, finished;
    start_addr = s;
    end_addr   = e;
    auto_mode  = 1'b1;
    start      = 1'b1;
    cycle();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_req", rd_req, 1);
    chk("first_addr", rd_addr, s);
    cur_a = s; exp_a = s + 8'd1; reads = 1; gap = 0;
    prev_req = 1'b1; in_hold = 1'b0; finished = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      acked = rd_ack;
      cycle();
      if (acked) begin
        chk("disp_pair", {ad_high, ad_low, d_high, d_low}, {cur_a, cur_a ^ 8'hA5});
        gap = 1;
        in_hold = 1'b1;
      end else if (in_hold && !rd_req && !done) begin
        gap++;
      end
      if (done) begin
        chk("hold_len_last", gap, 4);
        chk("busy_at_done", busy, 0);
        chk("read_count", reads, n_exp);
        finished = 1'b1;
      end
      if (rd_req && !prev_req) begin
        chk("hold_len", gap, 4);
        chk("scan_addr", rd_addr, exp_a);
        cur_a = exp_a;
        exp_a = exp_a + 8'd1;
        reads++;
        in_hold = 1'b0;
      end
      prev_req = rd_req;
    end
    chk("scan_done_seen", finished, 1);
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("idle_quiet", {done, rd_req, busy}, 0);
    end
    chk("disp_retained", {ad_high, ad_low, d_high, d_low}, {e, e ^ 8'hA5});
  endtask

  task automatic wait_display(output logic got);
    logic acked;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      acked = rd_ack;
      cycle();
      if (acked) got = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        got, found;
    int unsigned bad;
    reset = 1'b1; start = 1'b0; stop = 1'b0; step = 1'b0; auto_mode = 1'b1;
    start_addr = '0; end_addr = '0; rd_ack = 1'b0; rd_data = '0;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (10) cycle();
    chk("rst_disp", {ad_high, ad_low, d_high, d_low}, 0);
    chk("rst_req", rd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", rd_addr, 0);

    vecs[0] = '{s: 8'h10, e: 8'h12, n: 3};
    vecs[1] = '{s: 8'hFE, e: 8'h01, n: 4};
    vecs[2] = '{s: 8'h3C, e: 8'h3C, n: 1};
    vecs[3] = '{s: 8'h7F, e: 8'h81, n: 3};
    for (int i = 0; i < 4; i++) run_scan(vecs[i].s, vecs[i].e, vecs[i].n);

    // Manual mode, single address, step held high: one read, one done.
    auto_mode = 1'b0; start_addr = 8'h3C; end_addr = 8'h3C; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_display(got);
    chk("man_disp_seen", got, 1);
    chk("man_disp", {ad_high, ad_low, d_high, d_low}, 16'h3C99);
    bad = 0;
    repeat (8) begin cycle(); if (done || !busy || rd_req) bad++; end
    chk("man_waits", bad, 0);
    step = 1'b1;
    cycle();
    chk("man_done", done, 1);
    chk("man_busy_low", busy, 0);
    bad = 0;
    repeat (19) begin cycle(); if (rd_req || done) bad++; end
    chk("man_no_reread", bad, 0);
    step = 1'b0;
    cycle();

    // Held step advances once; switching to auto after the hold elapsed advances immediately.
    start_addr = 8'h40; end_addr = 8'h41; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_display(got);
    step = 1'b1;
    cycle();
    chk("held_step_req", rd_req, 1);
    chk("held_step_addr", rd_addr, 8'h41);
    bad = 0;
    repeat (15) begin cycle(); if (done || !busy) bad++; end
    chk("held_step_once", bad, 0);
    chk("held_step_disp", {ad_high, ad_low, d_high, d_low}, 16'h41E4);
    step = 1'b0;
    auto_mode = 1'b1;
    cycle();
    chk("mode_switch_done", done, 1);

    // stop coinciding with ack on 0x21: data discarded, no done, restart from start_addr.
    start_addr = 8'h20; end_addr = 8'h23; start = 1'b1;
    cycle();
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      cycle();
      if (rd_ack && rd_addr == 8'h21) found = 1'b1;
    end
    chk("stop_ack_found", found, 1);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_req", rd_req, 0);
    chk("stop_no_done", done, 0);
    chk("stop_disp", {ad_high, ad_low, d_high, d_low}, 16'h2085);
    bad = 0;
    repeat (3) begin cycle(); if (done || rd_req || busy) bad++; end
    chk("stop_idle", bad, 0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("restart_req", rd_req, 1);
    chk("restart_addr", rd_addr, 8'h20);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    chk("stop2_busy", busy, 0);

`ifdef MEMSEQ_ACK_TIMEOUT_EN
    begin
      int unsigned req_hi;
      logic        prev_req, fin;
      logic [7:0]  prev_addr;
      nack_en = 1'b1; nack_addr = 8'h05;
      start_addr = 8'h04; end_addr = 8'h06; auto_mode = 1'b1; start = 1'b1;
      cycle();
      start = 1'b0;
      req_hi = 0; fin = 1'b0; prev_req = rd_req; prev_addr = rd_addr;
      for (int c = 0; c < 100 && !fin; c++) begin
        cycle();
        if (rd_req && rd_addr == 8'h05) req_hi++;
        if (prev_req && !rd_req && prev_addr == 8'h05) begin
          chk("tmo_disp", {ad_high, ad_low, d_high, d_low}, 16'h05EE);
          chk("tmo_err", err, 1);
        end
        if (done) fin = 1'b1;
        prev_req = rd_req; prev_addr = rd_addr;
      end
      chk("tmo_scan_done", fin, 1);
      chk("tmo_req_len", req_hi, 8);
      chk("tmo_err_sticky", err, 1);
      nack_en = 1'b0;
      start_addr = 8'h06; end_addr = 8'h06; start = 1'b1;
      cycle();
      start = 1'b0;
      chk("tmo_err_clear", err, 0);
      fin = 1'b0;
      for (int c = 0; c < 40 && !fin; c++) begin cycle(); if (done) fin = 1'b1; end
      chk("tmo_rescan_done", fin, 1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
